// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: prefix codes, frame FSM states, FIFO entry layout.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_e;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_entry_t;

  // Frame bits in arrival order: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
  function automatic logic frame_ok(input logic [10:0] frame);
    return !frame[0] && (^frame[9:1]) && frame[10];
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 pin conditioning: 2-flop synchronisers, run-length glitch filter on the clock, falling-edge pulse.
module ps2_sync_filter #(
  parameter int FILT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall
);

  localparam int CW = $clog2(FILT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_filt;
  logic [CW-1:0] run;

  // Syncs reset to the idle-high line level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      run      <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      fall     <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        run <= '0;
      end else if (run == CW'(FILT - 1)) begin
        run      <= '0;
        clk_filt <= clk_sync[1];
        fall     <= clk_filt;
      end else begin
        run <= run + 1'b1;
      end
    end
  end

  assign data_sync = dat_sync[1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: frame FSM with parity/timeout checks, E0/F0 prefix folding, FWFT FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int FILT    = 4,
  parameter int TIMEOUT = 5000,
  parameter int DECODE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rd_en,
  input  logic                     err_clr,
  output logic [7:0]               data,
  output logic                     ext,
  output logic                     brk,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     parity_err,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic data_sync;
  logic fall;

  ps2_sync_filter #(.FILT(FILT)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data_sync),
    .fall      (fall)
  );

  // Stage p0: frame assembly and checking
  ps2_state_e    state;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmo;
  logic [10:0]   frame_p0;

  always_ff @(posedge clk) begin
    if (fall) frame_p0 <= {data_sync, frame_p0[10:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      tmo        <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (err_clr) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          tmo <= '0;
          // A high data bit on a falling edge is a mid-frame leftover; drop it to resync.
          if (fall && !data_sync) begin
            state   <= ST_RECV;
            bit_cnt <= 4'd1;
          end
        end
        ST_RECV: begin
          if (fall) begin
            tmo     <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd10) state <= ST_CHECK;
          end else if (tmo == TW'(TIMEOUT)) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        ST_CHECK: begin
          if (!frame_ok(frame_p0)) parity_err <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p1: prefix decoding
  logic       good_p0;
  logic [7:0] code_p0;
  logic       ext_pend;
  logic       brk_pend;
  logic       push_p1;
  ps2_entry_t entry_p1;

  assign good_p0 = (state == ST_CHECK) && frame_ok(frame_p0);
  assign code_p0 = frame_p0[8:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      push_p1  <= 1'b0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else begin
      push_p1 <= 1'b0;
      if (good_p0) begin
        if (DECODE != 0 && code_p0 == PS2_EXT_PREFIX) begin
          ext_pend <= 1'b1;
        end else if (DECODE != 0 && code_p0 == PS2_BRK_PREFIX) begin
          brk_pend <= 1'b1;
        end else begin
          push_p1  <= 1'b1;
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (good_p0) entry_p1 <= '{brk: brk_pend, ext: ext_pend, code: code_p0};
  end

  // Stage p2: FIFO storage
  ps2_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          wr;
  ps2_entry_t    head;

  assign ready = (level != '0);
  assign full  = (level == FULL_LVL);
  assign pop   = rd_en && ready;
  assign wr    = push_p1 && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= entry_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (err_clr) overflow <= 1'b0;
      if (push_p1 && full && !pop) overflow <= 1'b1;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Empty FIFO presents zeros rather than a stale slot.
  assign head = mem[rd_ptr];
  assign data = ready ? head.code : 8'h00;
  assign ext  = ready && head.ext;
  assign brk  = ready && head.brk;

endmodule
